// File: rtl/blk_accum_engine.sv
`default_nettype none
// ============================================================================
// Module   : blk_accum_engine
// Brief    : FIFO-fed streaming reducer; sums or XORs blocks of BLK_LEN words
//            and reports one registered result per block.
// Option   : BLK_ACCUM_SAT_EN - saturating sum mode (wraps when undefined)
// Revision : 1.0
// ============================================================================
module blk_accum_engine #(
  parameter int DATA_W     = 32,
  parameter int ACC_W      = 40,
  parameter int BLK_LEN    = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wen,
  output logic              rdy,
  input  logic              mode,
  output logic [ACC_W-1:0]  dout,
  output logic              done,
  output logic              ovf
);

  localparam int c_AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_IW = $clog2(BLK_LEN + 1);
  localparam logic [c_AW:0]   c_FULL = (c_AW + 1)'(FIFO_DEPTH);
  localparam logic [c_IW-1:0] c_LAST = c_IW'(BLK_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [c_AW-1:0]   r_wr_ptr;
  logic [c_AW-1:0]   r_rd_ptr;
  logic [c_AW:0]     r_count;
  logic [ACC_W-1:0]  r_acc;
  logic [c_IW-1:0]   r_idx;
  logic              r_mode;
  logic              r_ovf_acc;

  logic              w_push;
  logic              w_pop;
  logic [ACC_W-1:0]  w_ext;
  logic [ACC_W:0]    w_sum;
  logic              w_carry;
  logic [ACC_W-1:0]  w_sum_next;

  assign rdy    = (r_count != c_FULL);
  assign w_push = wen && rdy;
  assign w_pop  = (r_state != S_DONE) && (r_count != '0);

  assign w_ext   = ACC_W'(r_mem[r_rd_ptr]);
  assign w_sum   = {1'b0, r_acc} + {1'b0, w_ext};
  assign w_carry = w_sum[ACC_W];

`ifdef BLK_ACCUM_SAT_EN
  // Once a carry has been seen the block result pins at all-ones.
  assign w_sum_next = (w_carry || r_ovf_acc) ? '1 : w_sum[ACC_W-1:0];
`else
  assign w_sum_next = w_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_acc     <= '0;
      r_idx     <= '0;
      r_mode    <= 1'b0;
      r_ovf_acc <= 1'b0;
      dout      <= '0;
      done      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_mode    <= mode;
            r_acc     <= w_ext;
            r_idx     <= c_IW'(1);
            r_ovf_acc <= 1'b0;
            r_state   <= (BLK_LEN == 1) ? S_DONE : S_ACC;
          end
        end
        S_ACC: begin
          if (w_pop) begin
            if (r_mode) begin
              r_acc <= r_acc ^ w_ext;
            end else begin
              r_acc <= w_sum_next;
              if (w_carry) r_ovf_acc <= 1'b1;
            end
            r_idx <= r_idx + 1'b1;
            if (r_idx == c_LAST) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          dout    <= r_acc;
          ovf     <= r_ovf_acc;
          done    <= 1'b1;
          r_idx   <= '0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
